// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and constants for the nibble-serial adder
// Optional subtract support is enabled by SERIAL_ADD_SUB_EN in the top module.
package serial_add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sadd_state_t;

endpackage

// File: rtl/nibble_add.sv
// rtl/nibble_add.sv - combinational 4-bit ripple adder slice
// Exposes the carry into bit 3 so the controller can derive signed overflow.
module nibble_add
  import serial_add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                ci,
  output logic [NIBBLE_W-1:0] s,
  output logic                co,
  output logic                c3
);

  logic [NIBBLE_W:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < NIBBLE_W; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
  end

  assign co = c[NIBBLE_W];
  assign c3 = c[NIBBLE_W-1];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - sequences one nibble slice over WIDTH-bit operands, LSB first
// Define SERIAL_ADD_SUB_EN to add the sub port (A - B via inverted B and forced carry-in).
module nibble_serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = $clog2(NIBBLES);

  generate
    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
      $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 8");
    end
  endgenerate

  sadd_state_t      state_q, state_d;
  logic [IDX_W-1:0] nib_idx_q, nib_idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [NIBBLE_W-1:0] slice_s;
  logic                slice_co;
  logic                slice_c3;
  logic                accept;
  logic [WIDTH-1:0]    b_load;
  logic                carry_load;

  nibble_add u_slice (
    .a  (a_q[NIBBLE_W-1:0]),
    .b  (b_q[NIBBLE_W-1:0]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co),
    .c3 (slice_c3)
  );

  // Subtraction is folded into the load: B is stored inverted and the carry seeded with 1.
`ifdef SERIAL_ADD_SUB_EN
  assign b_load     = sub ? ~op_b : op_b;
  assign carry_load = sub ? 1'b1 : cin;
`else
  assign b_load     = op_b;
  assign carry_load = cin;
`endif

  assign accept = start && (state_q == IDLE || state_q == DONE);

  always_comb begin
    state_d   = state_q;
    nib_idx_d = nib_idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;

    case (state_q)
      IDLE: begin
        if (start) state_d = RUN;
      end
      RUN: begin
        sum_d[nib_idx_q*NIBBLE_W +: NIBBLE_W] = slice_s;
        carry_d = slice_co;
        a_d     = a_q >> NIBBLE_W;
        b_d     = b_q >> NIBBLE_W;
        if (nib_idx_q == IDX_W'(NIBBLES - 1)) begin
          cout_d  = slice_co;
          ovf_d   = slice_c3 ^ slice_co;
          state_d = DONE;
        end else begin
          nib_idx_d = nib_idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        state_d = start ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      a_d       = op_a;
      b_d       = b_load;
      carry_d   = carry_load;
      nib_idx_d = '0;
      sum_d     = '0;
      cout_d    = 1'b0;
      ovf_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      nib_idx_q <= '0;
      carry_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      nib_idx_q <= nib_idx_d;
      carry_q   <= carry_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb/tb_nibble_serial_add_ctrl.sv - directed self-checking bench for nibble_serial_add_ctrl
// Exercises the sub port when SERIAL_ADD_SUB_EN is defined.
module tb_nibble_serial_add_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        cin;
`ifdef SERIAL_ADD_SUB_EN
  logic        sub;
`endif
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;

  nibble_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_a     (op_a),
    .op_b     (op_b),
    .cin      (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub      (sub),
`endif
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic sb,
                        input logic [15:0] exp_sum, input logic exp_cout, input logic exp_ovf);
    op_a  = a;
    op_b  = b;
    cin   = ci;
`ifdef SERIAL_ADD_SUB_EN
    sub   = sb;
`else
    if (sb) $display("note: %s requests sub without SERIAL_ADD_SUB_EN", tag);
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk({tag, ".busy"}, 16'(busy), 16'd1);
      chk({tag, ".nodone"}, 16'(done), 16'd0);
      tick();
    end
    chk({tag, ".done"}, 16'(done), 16'd1);
    chk({tag, ".idle"}, 16'(busy), 16'd0);
    chk({tag, ".sum"}, sum, exp_sum);
    chk({tag, ".cout"}, 16'(cout), 16'(exp_cout));
    chk({tag, ".ovf"}, 16'(overflow), 16'(exp_ovf));
    tick();
    chk({tag, ".pulse"}, 16'(done), 16'd0);
    chk({tag, ".hold"}, sum, exp_sum);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    cin   = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
    sub   = 1'b0;
`endif
    tick();
    chk("rst.busy", 16'(busy), 16'd0);
    chk("rst.done", 16'(done), 16'd0);
    chk("rst.sum", sum, 16'h0000);
    chk("rst.cout", 16'(cout), 16'd0);
    chk("rst.ovf", 16'(overflow), 16'd0);
    rst = 1'b0;
    tick();

    run_op("t1", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("t2", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("t3a", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("t3b", 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);

    // start held through RUN must not disturb the in-flight operation
    op_a  = 16'h1111;
    op_b  = 16'h2222;
    cin   = 1'b0;
    start = 1'b1;
    tick();
    op_a  = 16'hAAAA;
    op_b  = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      chk("t4.busy", 16'(busy), 16'd1);
      tick();
    end
    chk("t4.done", 16'(done), 16'd1);
    chk("t4.sum", sum, 16'h3333);
    op_a = 16'h0102;
    op_b = 16'h0304;
    tick();
    start = 1'b0;
    chk("t4.drop", 16'(done), 16'd0);
    chk("t4.busy2", 16'(busy), 16'd1);
    chk("t4.clr", sum, 16'h0000);
    for (int i = 0; i < 3; i++) tick();
    chk("t4.early", 16'(done), 16'd0);
    tick();
    chk("t4.done2", 16'(done), 16'd1);
    chk("t4.sum2", sum, 16'h0406);
    tick();

    // asynchronous reset in the second RUN cycle
    op_a  = 16'h1234;
    op_b  = 16'h4321;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t5.prebusy", 16'(busy), 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5.busy", 16'(busy), 16'd0);
    chk("t5.done", 16'(done), 16'd0);
    chk("t5.sum", sum, 16'h0000);
    chk("t5.cout", 16'(cout), 16'd0);
    #2 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5.nodone", 16'(done), 16'd0);
    end
    run_op("t5b", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
    run_op("t6a", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("t6b", 16'h0009, 16'h0003, 1'b0, 1'b1, 16'h0006, 1'b1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
